// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared types and constants for the pipeline memory sequencer.
// Imported by the sequencer top and its stall encoder.
package pipe_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: byte_count = 3'd1;
      WIDTH_HALF: byte_count = 3'd2;
      WIDTH_WORD: byte_count = 3'd4;
      default:    byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    get_byte = word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] value);
    put_byte = word;
    put_byte[{idx, 3'b000} +: 8] = value;
  endfunction

endpackage

// File: rtl/pipe_mem_ctrl_stall_gen.sv
// Priority encoder turning pipeline hazards into the per-stage stall vector.
module pipe_mem_ctrl_stall_gen
  import pipe_mem_ctrl_pkg::*;
(
  input  logic       mem_busy,
  input  logic       stallreq_id,
  input  logic       if_busy,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    if (mem_busy) begin
      stall = STALL_MEM;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else if (if_busy) begin
      stall = STALL_IF;
    end
  end

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Shares one byte-wide synchronous RAM port between fetch and MEM using
// byte-serial bursts, and drives the pipeline stall vector.
module pipe_mem_ctrl
  import pipe_mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  output logic                      if_done,
  output logic [31:0]               if_inst,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [1:0]                mem_width,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_done,
  output logic [31:0]               mem_rdata,
  input  logic                      stallreq_id,
  input  logic                      flush,
  output logic [5:0]                stall,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_dout,
  input  logic [7:0]                ram_din,
  output logic                      ram_we
);

  state_t                    state;
  owner_t                    owner;
  logic [RAM_ADDR_WIDTH-1:0] base;
  logic [2:0]                count;
  logic [2:0]                c;
  logic [31:0]               wdata;
  logic [31:0]               rbuf;

  logic [2:0]                c_next;
  logic [1:0]                cap_idx;
  logic [RAM_ADDR_WIDTH-1:0] next_addr;
  logic [31:0]               rword;
  logic                      unused_addr_hi;

  assign c_next    = c + 3'd1;
  assign cap_idx   = c[1:0] - 2'd1;
  assign next_addr = base + RAM_ADDR_WIDTH'(c_next);
  assign rword     = put_byte(rbuf, cap_idx, ram_din);

  assign unused_addr_hi = ^{if_addr[31:RAM_ADDR_WIDTH], mem_addr[31:RAM_ADDR_WIDTH]};

  // RAM address/data are registered one cycle ahead so that the byte for
  // counter value c is on the port during the cycle the FSM holds c.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWNER_IF;
      base      <= '0;
      count     <= 3'd0;
      c         <= 3'd0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      if_done   <= 1'b0;
      if_inst   <= 32'd0;
      mem_done  <= 1'b0;
      mem_rdata <= 32'd0;
      ram_addr  <= '0;
      ram_dout  <= 8'd0;
      ram_we    <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          c      <= 3'd0;
          rbuf   <= 32'd0;
          ram_we <= 1'b0;
          if (mem_req) begin
            owner    <= OWNER_MEM;
            base     <= mem_addr[RAM_ADDR_WIDTH-1:0];
            count    <= byte_count(mem_width);
            wdata    <= mem_wdata;
            ram_addr <= mem_addr[RAM_ADDR_WIDTH-1:0];
            if (mem_we) begin
              state    <= ST_WR;
              ram_we   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end else begin
              state <= ST_RD;
            end
          end else if (if_req && !flush) begin
            owner    <= OWNER_IF;
            base     <= if_addr[RAM_ADDR_WIDTH-1:0];
            count    <= 3'd4;
            wdata    <= 32'd0;
            ram_addr <= if_addr[RAM_ADDR_WIDTH-1:0];
            state    <= ST_RD;
          end
        end

        ST_RD: begin
          if (owner == OWNER_IF && flush) begin
            state <= ST_IDLE;
          end else begin
            if (c != 3'd0) begin
              rbuf <= rword;
            end
            if (c == count) begin
              state <= ST_DONE;
              if (owner == OWNER_IF) begin
                if_inst <= rword;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= rword;
                mem_done  <= 1'b1;
              end
            end else begin
              c <= c_next;
              if (c_next < count) begin
                ram_addr <= next_addr;
              end
            end
          end
        end

        // One quiet cycle after the last write keeps store timing aligned with loads.
        ST_WR: begin
          if (c == count) begin
            state    <= ST_DONE;
            mem_done <= 1'b1;
          end else begin
            c <= c_next;
            if (c_next < count) begin
              ram_addr <= next_addr;
              ram_dout <= get_byte(wdata, c_next[1:0]);
              ram_we   <= 1'b1;
            end else begin
              ram_we <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pipe_mem_ctrl_stall_gen u_stall_gen (
    .mem_busy    (mem_req && !mem_done),
    .stallreq_id (stallreq_id),
    .if_busy     (if_req && !if_done),
    .stall       (stall)
  );

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl with a byte-wide synchronous RAM model;
// done responses are checked by a scoreboard monitor.
module tb_pipe_mem_ctrl;

  localparam int         AW         = 17;
  localparam int         RAM_SIZE   = 1 << AW;
  localparam logic [5:0] EXP_MEM    = 6'b011111;
  localparam logic [5:0] EXP_ID     = 6'b000111;
  localparam logic [5:0] EXP_IF     = 6'b000011;
  localparam logic [5:0] EXP_NONE   = 6'b000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_done;
  logic [31:0]   if_inst;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_width;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          stallreq_id;
  logic          flush;
  logic [5:0]    stall;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic          ram_we;

  logic [7:0]    tbram [0:RAM_SIZE-1];

  typedef struct {
    logic        is_if;
    logic        is_store;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_got;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_inst     (if_inst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_width   (mem_width),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .stallreq_id (stallreq_id),
    .flush       (flush),
    .stall       (stall),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .ram_din     (ram_din),
    .ram_we      (ram_we)
  );

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (ram_we) tbram[ram_addr] <= ram_dout;
    ram_din <= tbram[ram_addr];
  end

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_done || mem_done) begin
      mon_got = if_done ? if_inst : mem_rdata;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: if_done=%0b mem_done=%0b data=0x%08h, required no done",
                 if_done, mem_done, mon_got);
      end else begin
        mon_e = sb_q.pop_front();
        if (if_done && mem_done) begin
          errors++;
          $display("[TB] FAIL done_overlap: both done pulses high, required one");
        end else if (mon_e.is_if != if_done) begin
          errors++;
          $display("[TB] FAIL done_owner: if_done=%0b, required if_done=%0b", if_done, mon_e.is_if);
        end else if (!mon_e.is_store && mon_got !== mon_e.data) begin
          errors++;
          $display("[TB] FAIL done_data: got 0x%08h, required 0x%08h", mon_got, mon_e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic is_mem, input logic we, input logic [1:0] width,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic expect_done, input logic [31:0] exp_data);
    exp_t e;
    if (is_mem) begin
      mem_req   = 1'b1;
      mem_we    = we;
      mem_width = width;
      mem_addr  = addr;
      mem_wdata = wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    if (expect_done) begin
      e.is_if    = !is_mem;
      e.is_store = we;
      e.data     = exp_data;
      sb_q.push_back(e);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input logic want_mem, input int start, output int cycles);
    bit found = 1'b0;
    cycles = -1;
    for (int k = start; k < start + 30 && !found; k++) begin
      @(negedge clk);
      if (want_mem ? mem_done : if_done) begin
        cycles = k;
        found  = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    for (int i = 0; i < RAM_SIZE; i++) tbram[i] = 8'h00;
    tbram['h100] = 8'h13; tbram['h101] = 8'h05; tbram['h102] = 8'h00; tbram['h103] = 8'h00;
    tbram['h104] = 8'h93; tbram['h105] = 8'h00; tbram['h106] = 8'h10; tbram['h107] = 8'h00;
    tbram['h200] = 8'hEF; tbram['h201] = 8'hBE; tbram['h202] = 8'hAD; tbram['h203] = 8'hDE;
    tbram['h1FFFF] = 8'h34; tbram['h0] = 8'h12;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
    mem_width = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0; stallreq_id = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'(EXP_NONE));
    checkOutput("reset_strobes", 32'({if_done, mem_done, ram_we}), 32'd0);
    checkOutput("reset_if_inst", if_inst, 32'd0);
    checkOutput("reset_mem_rdata", mem_rdata, 32'd0);
    checkOutput("reset_ram_port", 32'({ram_addr, ram_dout}), 32'd0);
    nextCycle(); rst = 1'b1;

    stallreq_id = 1'b1;
    @(negedge clk);
    checkOutput("id_only_stall", 32'(stall), 32'(EXP_ID));
    nextCycle(); stallreq_id = 1'b0;

    $display("[TB] fetch word at 0x100");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b1, 32'h00000513);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("fetch_stall", 32'(stall), 32'(EXP_IF));
      checkOutput("fetch_ram_we", 32'(ram_we), 32'd0);
      if (k >= 1 && k <= 4) checkOutput("fetch_ram_addr", 32'(ram_addr), 32'h100 + 32'(k - 1));
    end
    waitDone(1'b0, 6, cyc);
    checkOutput("fetch_done_cycle", 32'(cyc), 32'd6);
    checkOutput("fetch_done_stall", 32'(stall), 32'(EXP_NONE));
    nextCycle(); if_req = 1'b0;

    $display("[TB] word load at 0x200 competing with fetch");
    nextCycle();
    stallreq_id = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h200, 32'd0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h104, 32'd0, 1'b1, 32'h00100093);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("load_stall", 32'(stall), 32'(EXP_MEM));
    end
    waitDone(1'b1, 6, cyc);
    checkOutput("load_done_cycle", 32'(cyc), 32'd6);
    checkOutput("load_done_stall", 32'(stall), 32'(EXP_ID));
    nextCycle(); mem_req = 1'b0; stallreq_id = 1'b0;
    @(negedge clk);
    checkOutput("fetch_after_load_stall", 32'(stall), 32'(EXP_IF));
    waitDone(1'b0, 8, cyc);
    checkOutput("fetch_after_load_cycle", 32'(cyc), 32'd13);
    nextCycle(); if_req = 1'b0;

    $display("[TB] byte store 0xA5 to 0x7");
    nextCycle();
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h7, 32'h123456A5, 1'b1, 32'd0);
    @(negedge clk);
    checkOutput("store_t0_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    checkOutput("store_t1_we", 32'(ram_we), 32'd1);
    checkOutput("store_t1_addr", 32'(ram_addr), 32'h7);
    checkOutput("store_t1_dout", 32'(ram_dout), 32'hA5);
    @(negedge clk);
    checkOutput("store_t2_we", 32'(ram_we), 32'd0);
    waitDone(1'b1, 3, cyc);
    checkOutput("store_done_cycle", 32'(cyc), 32'd3);
    nextCycle(); mem_req = 1'b0; mem_we = 1'b0;
    checkOutput("store_ram_byte", 32'(tbram['h7]), 32'hA5);
    checkOutput("store_ram_neighbour", 32'(tbram['h8]), 32'h00);

    $display("[TB] half load across the address wrap");
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h1FFFF, 32'd0, 1'b1, 32'h00001234);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_addr0", 32'(ram_addr), 32'h1FFFF);
    @(negedge clk);
    checkOutput("wrap_addr1", 32'(ram_addr), 32'h0);
    waitDone(1'b1, 3, cyc);
    checkOutput("wrap_done_cycle", 32'(cyc), 32'd4);
    nextCycle(); mem_req = 1'b0;

    $display("[TB] flush during fetch");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 32'd0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h104, 32'd0, 1'b1, 32'h00100093);
    flush = 1'b1;
    nextCycle(); flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush_refetch_addr", 32'(ram_addr), 32'h104);
    waitDone(1'b0, 5, cyc);
    checkOutput("flush_done_cycle", 32'(cyc), 32'd9);
    nextCycle(); if_req = 1'b0;

    $display("[TB] reset in the middle of a word store");
    tbram['h300] = 8'h00; tbram['h301] = 8'h00;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h300, 32'hCAFEBABE, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rststore_t1_we", 32'(ram_we), 32'd1);
    checkOutput("rststore_t1_dout", 32'(ram_dout), 32'hBE);
    nextCycle(); rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    checkOutput("rststore_we_drop", 32'(ram_we), 32'd0);
    nextCycle(); rst = 1'b1;
    @(negedge clk);
    checkOutput("rststore_stall", 32'(stall), 32'(EXP_NONE));
    checkOutput("rststore_we_after", 32'(ram_we), 32'd0);
    nextCycle();
    checkOutput("rststore_byte0", 32'(tbram['h300]), 32'hBE);
    checkOutput("rststore_byte1", 32'(tbram['h301]), 32'h00);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h300, 32'd0, 1'b1, 32'h000000BE);
    waitDone(1'b1, 0, cyc);
    checkOutput("byte_load_cycle", 32'(cyc), 32'd3);
    nextCycle(); mem_req = 1'b0;

    repeat (4) nextCycle();
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_ctrl.md
Name: pipe_mem_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core.
- Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Runs multi-byte accesses as byte-serial bursts.
- Generates the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.

Parameters:
- RAM_ADDR_WIDTH, 17, number of ram_addr bits driven (low bits of the byte address).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle pulse; if_inst valid.
- if_inst  out  32  fetched word, little-endian.
- mem_req  in  1  load/store request, held until mem_done.
- mem_we  in  1  1 = store.
- mem_width  in  2  0 = byte, 1 = half, 2/3 = word.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data; low bytes used.
- mem_done  out  1  one-cycle pulse.
- mem_rdata  out  32  load data, zero-extended raw bytes.
- stallreq_id  in  1  load-use hazard from ID.
- flush  in  1  taken branch/jump from EX.
- stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb.
- ram_addr  out  RAM_ADDR_WIDTH  byte address to RAM.
- ram_dout  out  8  write byte.
- ram_din  in  8  read byte; synchronous RAM, valid the cycle after its address.
- ram_we  out  1  write enable.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: FSM = IDLE, counter = 0, all captured data = 0. Outputs if_done = 0, mem_done = 0, if_inst = 0, mem_rdata = 0, ram_we = 0, ram_addr = 0, ram_dout = 0, stall = 0.
- FSM states: IDLE, RD, WR, DONE. Registered context: requester (IF/MEM), base address, byte count N (1/2/4), write data, counter c.
- IDLE, cycle T: accept a request.
  - mem_req has priority over if_req.
  - IF access: N = 4, read.
  - mem_we = 1 goes to WR, otherwise RD.
  - RAM idle in IDLE: ram_we = 0.
- RD, entered T+1:
  - Each cycle: if c < N, ram_addr = base + c. If c >= 1, capture ram_din into byte c-1.
  - When c = N (last byte captured): go to DONE.
  - Word read: addresses T+1..T+4, done at T+6.
- WR, entered T+1:
  - Each cycle: ram_addr = base + c, ram_dout = wdata byte c, ram_we = 1.
  - After c = N-1: go to DONE.
  - Word store done at T+6; byte store done at T+3.
- DONE: pulse the owning requester's *_done with data valid; next state IDLE unconditionally. The held request is not re-accepted that cycle.
- Unused upper bytes of mem_rdata read as 0. Address arithmetic wraps modulo 2^RAM_ADDR_WIDTH.
- flush while the current access is an IF read (RD, or IDLE accepting if_req): abort to IDLE next cycle, no if_done. The pending if_req is re-served with the new address.
- flush during a MEM access: ignored (EX is frozen).
- Stall vector, combinational, priority high to low:
  - mem_busy = mem_req && !mem_done → 6'b011111.
  - stallreq_id → 6'b000111.
  - if_busy = if_req && !if_done → 6'b000011.
  - otherwise 6'b000000.
- Done-cycle rule: a done pulse removes that requester's stall term in the same cycle, so the stage register latches the data.
- Async reset mid-burst: FSM to IDLE and ram_we = 0 immediately. No partial done; a partial write may remain in RAM.

Decomposition:
- Shared defines header holds:
  - stall encodings STALL_MEM, STALL_ID, STALL_IF, STALL_NONE.
  - width codes WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD.
  - FSM state codes.
- One natural sub-module: stall_gen, combinational priority encoder producing stall from mem_busy/stallreq_id/if_busy.

Test Plan:
- IF fetch, RAM holds 0x13,0x05,0x00,0x00 at addr 0x100 → ram_addr 0x100..0x103 on T+1..T+4; if_done at T+6 with if_inst = 0x00000513; stall = 6'b000011 through T+5, then 0.
- Word load at 0x200 while if_req high → MEM wins: stall = 6'b011111 until mem_done at T+6, mem_rdata = RAM word; IF served next, starting in the IDLE cycle after DONE.
- Store byte 0xA5 (mem_wdata = 0x123456A5, width 0) to 0x7 → single ram_we cycle at T+1 with ram_addr = 0x7, ram_dout = 0xA5; mem_done at T+3.
- Half load at 0x1FFFF with RAM_ADDR_WIDTH = 17 → addresses 0x1FFFF then 0x00000; mem_rdata upper 16 bits = 0.
- flush asserted at T+2 of a fetch → no if_done; new fetch begins within 2 cycles and completes with the new address's word.
- rst low at T+2 of a word store → ram_we drops immediately; state IDLE, stall = 0 after release; only byte 0 written.
